// File: rtl/lcd_pkg.sv
// Shared constants and FSM encoding for the LCD text frame buffer.
package lcd_pkg;

    localparam int GLYPH_W = 16;
    localparam int GLYPH_H = 16;
    localparam int CODE_W  = 6;
    localparam int PAGE_H  = 8;

    localparam logic [1:0] ST_LOAD   = 2'd0;
    localparam logic [1:0] ST_FETCH  = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;

    localparam logic [CODE_W-1:0] BLANK = 6'h00;
    localparam logic [CODE_W-1:0] SOLID = 6'h3F;

endpackage

// File: rtl/lcd_text_fb_if.sv
// Byte stream handshake from the frame buffer to the LCD column writer.
interface lcd_text_fb_if #(
    parameter int COLS = 4,
    parameter int ROWS = 4
);

    localparam int PW = $clog2(ROWS * 2);
    localparam int CW = $clog2(COLS * 16);

    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] page_idx;
    logic [CW-1:0] col_idx;

    modport master (
        output out_data,
        output out_valid,
        output page_idx,
        output col_idx,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  page_idx,
        input  col_idx,
        output out_ready
    );

endinterface

// File: rtl/lcd_glyph_rom.sv
// Combinational glyph table: 6-bit code -> 16x16 bitmap, line 0 in MSBs.
module lcd_glyph_rom
    import lcd_pkg::*;
(
    input  logic [CODE_W-1:0]          code,
    output logic [GLYPH_W*GLYPH_H-1:0] glyph
);

    always_comb begin
        glyph = '0;
        for (int r = 0; r < GLYPH_H; r++) begin
            unique case (1'b1)
                code == BLANK:
                    glyph[(GLYPH_H-1-r)*GLYPH_W +: GLYPH_W] = '0;
                code == SOLID:
                    glyph[(GLYPH_H-1-r)*GLYPH_W +: GLYPH_W] = '1;
                default:
                    glyph[(GLYPH_H-1-r)*GLYPH_W +: GLYPH_W] =
                        {code, 4'(r), code};
            endcase
        end
    end

endmodule

// File: rtl/lcd_text_fb.sv
// Text-to-pixel frame buffer streaming 8-line LCD pages column by column.
// Optional LCD_FB_INVERT_EN adds an `invert` input that complements out_data.
module lcd_text_fb
    import lcd_pkg::*;
#(
    parameter int COLS = 4,
    parameter int ROWS = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [ROWS*COLS*CODE_W-1:0] text_in,
    input  logic                       text_upd,
`ifdef LCD_FB_INVERT_EN
    input  logic                       invert,
`endif
    lcd_text_fb_if.master              bus,
    output logic                       frame_done,
    output logic                       busy
);

    localparam int W  = COLS * GLYPH_W;
    localparam int NL = ROWS * GLYPH_H;
    localparam int NP = NL / PAGE_H;
    localparam int LW = $clog2(NL);
    localparam int PW = $clog2(NP);
    localparam int CW = $clog2(W);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int TW = ROWS * COLS * CODE_W;

    logic [1:0]    state_q, state_d;
    logic [LW-1:0] line_q, line_d;
    logic [3:0]    fcnt_q, fcnt_d;
    logic [PW-1:0] page_q, page_d;
    logic [CW-1:0] col_q, col_d;
    logic          pend_q, pend_d;
    logic          fd_q, fd_d;
    logic [TW-1:0] text_q, text_d;
    logic [0:W-1]  pg_q [PAGE_H];
    logic [0:W-1]  pg_d [PAGE_H];

    logic [W-1:0]  mem [NL];
    logic [W-1:0]  ram_rd_q;
    logic [W-1:0]  ram_wdata;
    logic [LW-1:0] ram_addr;
    logic          ram_we;

    logic [TW-1:0]     cur_text;
    logic [CODE_W-1:0] txt [ROWS][COLS];
    logic [RW-1:0]     row;
    logic [3:0]        gl;
    logic [7:0]        byte_n;
    logic              valid;
    logic              last_col;
    logic              last_page;
    logic              inv;

    // Text is captured on the first LOAD cycle, which also renders line 0.
    assign cur_text = (line_q == '0) ? text_in : text_q;
    assign row      = RW'(line_q >> 4);
    assign gl       = line_q[3:0];

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_chr
            assign txt[r][c] =
                cur_text[(ROWS*COLS-1-(r*COLS+c))*CODE_W +: CODE_W];
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_col
        logic [GLYPH_W*GLYPH_H-1:0] glyph;
        lcd_glyph_rom u_rom (
            .code  (txt[row][c]),
            .glyph (glyph)
        );
        assign ram_wdata[(COLS-1-c)*GLYPH_W +: GLYPH_W] =
            glyph[{~gl, 4'b0000} +: GLYPH_W];
    end

    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rd_q <= mem[ram_addr];
    end

    assign last_col  = (col_q == CW'(W - 1));
    assign last_page = (page_q == PW'(NP - 1));

    always_comb begin
        state_d  = state_q;
        line_d   = line_q;
        fcnt_d   = fcnt_q;
        page_d   = page_q;
        col_d    = col_q;
        pend_d   = pend_q | text_upd;
        fd_d     = 1'b0;
        text_d   = text_q;
        pg_d     = pg_q;
        ram_we   = 1'b0;
        ram_addr = line_q;
        unique case (1'b1)
            state_q == ST_LOAD: begin
                ram_we = 1'b1;
                if (line_q == '0) text_d = text_in;
                if (line_q == LW'(NL - 1)) begin
                    line_d  = '0;
                    page_d  = '0;
                    fcnt_d  = '0;
                    state_d = ST_FETCH;
                end else begin
                    line_d = line_q + 1'b1;
                end
            end
            state_q == ST_FETCH: begin
                // Read data lags the address by one cycle.
                ram_addr = {page_q, fcnt_q[2:0]};
                if (fcnt_q != '0) pg_d[3'(fcnt_q - 4'd1)] = ram_rd_q;
                if (fcnt_q == 4'(PAGE_H)) begin
                    fcnt_d  = '0;
                    col_d   = '0;
                    state_d = ST_STREAM;
                end else begin
                    fcnt_d = fcnt_q + 4'd1;
                end
            end
            state_q == ST_STREAM: begin
                if (bus.out_ready) begin
                    if (!last_col) begin
                        col_d = col_q + 1'b1;
                    end else begin
                        col_d = '0;
                        if (!last_page) begin
                            page_d  = page_q + 1'b1;
                            state_d = ST_FETCH;
                        end else begin
                            fd_d   = 1'b1;
                            page_d = '0;
                            if (pend_d) begin
                                pend_d  = 1'b0;
                                line_d  = '0;
                                state_d = ST_LOAD;
                            end else begin
                                state_d = ST_FETCH;
                            end
                        end
                    end
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LOAD;
            line_q  <= '0;
            fcnt_q  <= '0;
            page_q  <= '0;
            col_q   <= '0;
            pend_q  <= 1'b0;
            fd_q    <= 1'b0;
            text_q  <= '0;
            for (int i = 0; i < PAGE_H; i++) pg_q[i] <= '0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            fcnt_q  <= fcnt_d;
            page_q  <= page_d;
            col_q   <= col_d;
            pend_q  <= pend_d;
            fd_q    <= fd_d;
            text_q  <= text_d;
            pg_q    <= pg_d;
        end
    end

`ifdef LCD_FB_INVERT_EN
    logic inv_q, inv_d;

    always_comb begin
        inv_d = inv_q;
        if (state_q == ST_FETCH && fcnt_q == '0) inv_d = invert;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) inv_q <= 1'b0;
        else        inv_q <= inv_d;
    end

    assign inv = inv_q;
`else
    assign inv = 1'b0;
`endif

    always_comb begin
        byte_n = '0;
        for (int i = 0; i < PAGE_H; i++) byte_n[PAGE_H-1-i] = pg_q[i][col_q];
    end

    assign valid         = (state_q == ST_STREAM);
    assign bus.out_valid = valid;
    assign bus.out_data  = valid ? (byte_n ^ {8{inv}}) : 8'h00;
    assign bus.page_idx  = page_q;
    assign bus.col_idx   = col_q;
    assign frame_done    = fd_q;
    assign busy          = (state_q == ST_LOAD);

endmodule

// File: tb/tb_lcd_text_fb.sv
// Directed bench for lcd_text_fb at 4x4 text: 8 pages x 64 columns per frame.
`timescale 1ns/1ps
module tb_lcd_text_fb;
    import lcd_pkg::*;

    localparam int COLS = 4;
    localparam int ROWS = 4;
    localparam int TW   = ROWS * COLS * CODE_W;
    localparam int NB   = 512;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b1;
    logic          text_upd = 1'b0;
    logic [TW-1:0] text_in  = '0;
    logic          frame_done;
    logic          busy;
`ifdef LCD_FB_INVERT_EN
    logic          invert   = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;

    lcd_text_fb_if #(.COLS(COLS), .ROWS(ROWS)) bus ();

    lcd_text_fb #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .text_in    (text_in),
        .text_upd   (text_upd),
`ifdef LCD_FB_INVERT_EN
        .invert     (invert),
`endif
        .bus        (bus),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int mode, input int pg,
                                            input int col);
        case (mode)
            0:       return 8'h00;
            1:       return (pg < 2 && col < 16) ? 8'hFF : 8'h00;
            default: return 8'hFF;
        endcase
    endfunction

    task automatic count_busy(input int upd_at, output int n);
        n = 0;
        while (busy && n < 200) begin
            text_upd = (n == upd_at);
            n++;
            @(negedge clk);
        end
        text_upd = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic stream_frame(input int mode, input bit toggle,
                                input int upd_at);
        int   n   = 0;
        int   cyc = 0;
        logic rdy = 1'b0;
        while (n < NB && cyc < 4000) begin
            if (bus.out_valid) begin
                chk("data", bus.out_data, exp_byte(mode, n / 64, n % 64));
                chk("page_idx", bus.page_idx, n / 64);
                chk("col_idx", bus.col_idx, n % 64);
                chk("fd_early", frame_done, 0);
            end
            rdy = toggle ? ~rdy : 1'b1;
            bus.out_ready = rdy;
            text_upd = bus.out_valid && rdy && (n == upd_at);
            if (bus.out_valid && rdy) n++;
            cyc++;
            @(negedge clk);
        end
        text_upd = 1'b0;
        bus.out_ready = 1'b1;
        chk("frame_len", n, NB);
        chk("frame_done", frame_done, 1);
    endtask

    initial begin
        int n;
        logic [TW-1:0] p1;
        p1 = '0;
        p1[TW-1 -: CODE_W] = SOLID;
        bus.out_ready = 1'b1;

        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_data", bus.out_data, 8'h00);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_page", bus.page_idx, 0);
        chk("rst_col", bus.col_idx, 0);
        chk("rst_fd", frame_done, 0);
        chk("rst_busy", busy, 1);

        rst_n = 1'b1;
        count_busy(-1, n);
        chk("load_len", n, 64);
        wait_valid(n);
        chk("fetch_len", n, 9);
        text_in = p1;
        stream_frame(0, 1'b0, 100);
        chk("pending_load", busy, 1);

        count_busy(-1, n);
        chk("load_len2", n, 64);
        wait_valid(n);
        chk("fetch_len2", n, 9);
        stream_frame(1, 1'b0, -1);
        chk("refresh", busy, 0);

        wait_valid(n);
        chk("refresh_fetch", n, 9);
        text_in = '1;
        stream_frame(1, 1'b1, NB - 1);
        chk("upd_last_busy", busy, 1);

        count_busy(10, n);
        chk("load_len3", n, 64);
        text_in = '0;
        wait_valid(n);
        chk("fetch_len3", n, 9);
        stream_frame(2, 1'b0, -1);
        chk("extra_load", busy, 1);

        count_busy(-1, n);
        chk("load_len4", n, 64);
        wait_valid(n);
        chk("fetch_len4", n, 9);
        stream_frame(0, 1'b0, -1);
        chk("pend_cleared", busy, 0);

        wait_valid(n);
        repeat (10) @(negedge clk);
        chk("mid_valid", bus.out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", bus.out_valid, 0);
        chk("arst_busy", busy, 1);
        chk("arst_data", bus.out_data, 8'h00);
        chk("arst_col", bus.col_idx, 0);

`ifdef LCD_FB_INVERT_EN
        text_in = '0;
        invert  = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        count_busy(-1, n);
        wait_valid(n);
        for (int i = 0; i < 4; i++) begin
            chk("invert", bus.out_data, 8'hFF);
            @(negedge clk);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lcd_text_fb.md
LCD_TEXT_FB -- requirements
Module: lcd_text_fb

Interface
REQ-001 Parameter COLS, default 4, meaning characters per text row (legal 1..8).
REQ-002 Parameter ROWS, default 4, meaning text rows (legal 1..8).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 text_in  input  ROWS*COLS*6  glyph codes; row 0 char 0 in MSBs, row-major.
REQ-006 text_upd  input  1  single-cycle request to re-render text_in.
REQ-007 out_ready  input  1  downstream accepts out_data this cycle.
REQ-008 out_data  output  8  one LCD column byte; bit7 = top line of the 8-line page.
REQ-009 out_valid  output  1  out_data valid.
REQ-010 page_idx  output  clog2(ROWS*2)  page of current byte.
REQ-011 col_idx  output  clog2(COLS*16)  pixel column of current byte.
REQ-012 frame_done  output  1  one-cycle pulse after the last byte of the last page is accepted.
REQ-013 busy  output  1  high while in LOAD.

Function
REQ-014 The frame buffer SHALL hold ROWS*16 lines of COLS*16 bits each; glyphs are 16x16 pixels.
REQ-015 States: LOAD, PAGE_FETCH, STREAM.
REQ-016 LOAD: latch text_in on entry; write one line per cycle, line L built from row L/16, glyph line L%16, char 0 in MSBs; ROWS*16 cycles, then PAGE_FETCH page 0.
REQ-017 PAGE_FETCH: read lines 8p..8p+7 through the synchronous-read buffer into an 8-line page register; 9 cycles, then STREAM.
REQ-018 STREAM: byte c = {line 8p+0 bit c, ..., line 8p+7 bit c}, bit index counted from MSB; c = 0..COLS*16-1.
REQ-019 Handshake: a byte transfers when out_valid && out_ready; out_data, page_idx and col_idx are held stable while out_valid && !out_ready.
REQ-020 After the last byte of a page transfers, the next page enters PAGE_FETCH; out_valid is low during fetch.
REQ-021 After the last byte of page ROWS*2-1 transfers: frame_done pulses 1 cycle; if an update is pending, go to LOAD and clear pending; else go to PAGE_FETCH page 0 (continuous refresh).
REQ-022 text_upd at any time sets pending; text_upd in the same cycle as the final byte transfer SHALL take effect immediately (LOAD next).
REQ-023 text_upd during LOAD: text is not re-latched; pending remains set and is serviced at the next frame end.
REQ-024 Counters wrap only at their stated bounds; no byte is dropped or duplicated under arbitrary out_ready patterns.

Reset
REQ-025 Reset SHALL clear the buffer-line counter, page and column counters, the page register and pending; state := LOAD.
REQ-026 Output reset values: out_data 0, out_valid 0, page_idx 0, col_idx 0, frame_done 0, busy 1.
REQ-027 Reset mid-stream aborts the frame; after release, a full LOAD precedes any output.

Configuration
REQ-028 With LCD_FB_INVERT_EN defined: extra input invert (1 bit, sampled at each page-fetch start) and out_data SHALL be the bitwise complement of the normal byte when invert=1.
REQ-029 Without LCD_FB_INVERT_EN: no invert port; out_data is always the normal byte.

Structure
REQ-030 Shared package lcd_pkg: GLYPH_W=16, GLYPH_H=16, CODE_W=6, PAGE_H=8, state encoding, glyph code constants (BLANK=6'h00, SOLID=6'h3F).
REQ-031 Sub-module lcd_glyph_rom: combinational code -> 256-bit glyph, one instance per column; code 0 is all zeros, code 63 is all ones.
REQ-032 The frame buffer SHALL be an inferred single-port synchronous RAM inside lcd_text_fb.

Verification
REQ-033 Reset; all codes 6'h00, out_ready=1 -> busy for 64 cycles, then 8 pages x 64 bytes of 8'h00, frame_done after byte 512.
REQ-034 Row 0 char 0 = 6'h3F, others 6'h00 -> page 0 and 1 cols 0..15 = 8'hFF, cols 16..63 = 8'h00; pages 2..7 all 8'h00.
REQ-035 out_ready toggled 1/0 every cycle -> identical byte sequence to REQ-034; data held during stalls.
REQ-036 text_upd mid-frame with new text all 6'h3F -> current frame completes unchanged, LOAD, next frame all 8'hFF.
REQ-037 text_upd in the cycle of final transfer -> busy next cycle; text_upd during LOAD -> one extra LOAD after next frame.
REQ-038 LCD_FB_INVERT_EN with invert=1, all codes 6'h00 -> all bytes 8'hFF; rst_n asserted mid-page -> out_valid 0 asynchronously, busy 1.
